// File: rtl/sub_sat_stage_32bit_signed_pkg.sv
// Shared widths, saturation limits and buffer-state encoding for the
// saturating subtract output stage.
package sub_stage_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // A stored word and its clamp flag travel together through the buffer.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sat;
  } stage_word_t;

endpackage

// File: rtl/sub_sat_stage_32bit_signed_clamp.sv
// Combinational clamp: an overflowed wrapped difference has the wrong sign,
// so the saturation rail is chosen opposite to the observed sign bit.
module sub_sat_clamp
  import sub_stage_pkg::*;
(
  input  logic [DATA_W-1:0] in_diff,
  input  logic              in_ovf,
  input  logic              sat_en,
  output logic [DATA_W-1:0] data,
  output logic              sat
);

  always_comb begin
    data = in_diff;
    sat  = 1'b0;
    if (sat_en && in_ovf) begin
      data = in_diff[DATA_W-1] ? SAT_MAX : SAT_MIN;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/sub_sat_stage_32bit_signed.sv
// Two-entry skid buffer with saturation applied at acceptance, plus a
// saturating overflow event counter and sticky flag.
module sub_sat_stage_32bit_signed
  import sub_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_diff,
  input  logic              in_ovf,
  input  logic              sat_en,
  input  logic              cnt_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  buf_state_t  state_q, state_d;
  stage_word_t main_q, main_d;
  stage_word_t skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic        ovf_sticky_q, ovf_sticky_d;

  stage_word_t clamp_word;
  logic        in_xfer;
  logic        out_xfer;

  sub_sat_clamp u_clamp (
    .in_diff (in_diff),
    .in_ovf  (in_ovf),
    .sat_en  (sat_en),
    .data    (clamp_word.data),
    .sat     (clamp_word.sat)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (in_xfer) begin
          main_d  = clamp_word;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = clamp_word;
        end else if (in_xfer) begin
          skid_d  = clamp_word;
          state_d = BUF_FULL;
        end else if (out_xfer) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // in_ready is low here, so only the drain can happen.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    in_ready_d  = (state_d != BUF_FULL);
    out_valid_d = (state_d != BUF_EMPTY);
  end

  // Clear takes priority but still counts a same-cycle overflowed word.
  always_comb begin
    ovf_count_d  = ovf_count_q;
    ovf_sticky_d = ovf_sticky_q;
    if (cnt_clr) begin
      ovf_count_d  = (in_xfer && in_ovf) ? CNT_W'(1) : '0;
      ovf_sticky_d = in_xfer && in_ovf;
    end else if (in_xfer && in_ovf) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != CNT_MAX) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BUF_EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      ovf_count_q  <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      ovf_count_q  <= ovf_count_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = main_q.data;
  assign out_sat    = main_q.sat;
  assign ovf_count  = ovf_count_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_sub_sat_stage_32bit_signed.sv
// Directed bench for the saturating skid stage; a 4-bit-counter copy shares
// the stimulus so counter saturation is reachable in few cycles.
module tb_sub_sat_stage_32bit_signed;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_diff;
  logic        in_ovf;
  logic        sat_en;
  logic        cnt_clr;
  logic        out_ready;

  logic        in_ready, out_valid, out_sat, ovf_sticky;
  logic [31:0] out_data;
  logic [15:0] ovf_count;

  logic        in_ready4, out_valid4, out_sat4, ovf_sticky4;
  logic [31:0] out_data4;
  logic [3:0]  ovf_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sub_sat_stage_32bit_signed #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_diff(in_diff), .in_ovf(in_ovf), .sat_en(sat_en), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  sub_sat_stage_32bit_signed #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_diff(in_diff), .in_ovf(in_ovf), .sat_en(sat_en), .cnt_clr(cnt_clr),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_sat(out_sat4), .ovf_sticky(ovf_sticky4), .ovf_count(ovf_count4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ref_clamp(input logic [31:0] d, input logic ovf, input logic en);
    if (en && ovf) return {1'b1, (d[31] ? 32'h7FFF_FFFF : 32'h8000_0000)};
    return {1'b0, d};
  endfunction

  initial begin
    logic [32:0] exp_w;
    logic [31:0] r_diff;
    logic        r_ovf, r_en;
    int          exp_cnt;

    rst = 1'b1; in_valid = 0; in_diff = '0; in_ovf = 0; sat_en = 0;
    cnt_clr = 0; out_ready = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_count", ovf_count, 0);
    check("rst_sticky", ovf_sticky, 0);
    step();
    rst = 1'b0;

    // Negative-looking overflowed result clamps to the positive rail.
    sat_en = 1; in_diff = 32'h8000_0001; in_ovf = 1; in_valid = 1; out_ready = 1;
    step();
    check("sat_pos_valid", out_valid, 1);
    check("sat_pos_data", out_data, 32'h7FFF_FFFF);
    check("sat_pos_sat", out_sat, 1);
    check("sat_pos_cnt", ovf_count, 1);
    check("sat_pos_cnt4", ovf_count4, 1);

    sat_en = 0; in_diff = 32'h7FFF_FFFE; in_ovf = 1;
    step();
    check("nosat_data", out_data, 32'h7FFF_FFFE);
    check("nosat_sat", out_sat, 0);
    check("nosat_sticky", ovf_sticky, 1);
    check("nosat_cnt", ovf_count, 2);

    sat_en = 1; in_diff = 32'h7FFF_FFFF; in_ovf = 1;
    step();
    check("sat_neg_data", out_data, 32'h8000_0000);
    check("sat_neg_sat", out_sat, 1);

    in_diff = 32'h0000_0123; in_ovf = 0;
    step();
    check("plain_data", out_data, 32'h0000_0123);
    check("plain_sat", out_sat, 0);
    check("plain_cnt", ovf_count, 3);

    in_valid = 0;
    step();
    check("drain_empty", out_valid, 0);

    cnt_clr = 1;
    step();
    check("clr_cnt", ovf_count, 0);
    check("clr_sticky", ovf_sticky, 0);
    cnt_clr = 0;

    // Back-pressure fills main then skid; third word must wait.
    sat_en = 0; in_ovf = 0; out_ready = 0; in_valid = 1; in_diff = 5;
    step();
    check("bp_w5_data", out_data, 5);
    check("bp_w5_ready", in_ready, 1);
    in_diff = 6;
    step();
    check("bp_w6_ready", in_ready, 0);
    check("bp_w6_hold", out_data, 5);
    in_diff = 7;
    step();
    check("bp_w7_ready", in_ready, 0);
    check("bp_w7_hold", out_data, 5);
    out_ready = 1;
    step();
    check("rel_data6", out_data, 6);
    check("rel_ready", in_ready, 1);
    step();
    check("rel_data7", out_data, 7);
    check("rel_valid7", out_valid, 1);
    in_valid = 0;
    step();
    check("rel_empty", out_valid, 0);

    // Counter saturation on the 4-bit copy.
    in_valid = 1; in_ovf = 1; sat_en = 0;
    for (int i = 0; i < 20; i++) begin
      in_diff = 32'(i);
      step();
    end
    check("cnt4_hold", ovf_count4, 15);
    check("cnt16_20", ovf_count, 20);
    cnt_clr = 1;
    step();
    check("clr_ovf_cnt4", ovf_count4, 1);
    check("clr_ovf_cnt16", ovf_count, 1);
    check("clr_ovf_sticky", ovf_sticky, 1);
    cnt_clr = 0; in_valid = 0; in_ovf = 0;
    step();

    // Reset with a full buffer discards both words immediately.
    out_ready = 0; in_valid = 1; in_diff = 32'hA;
    step();
    in_diff = 32'hB;
    step();
    check("full_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    in_valid = 0;
    #2 rst = 1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_data", out_data, 0);
    step();
    rst = 0;
    out_ready = 1;
    step();
    check("post_rst_no_stale", out_valid, 0);
    in_valid = 1; in_diff = 32'h55;
    step();
    check("post_rst_first", {out_valid, out_data}, {1'b1, 32'h55});

    // Streaming against the reference clamp.
    exp_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      r_diff = $urandom;
      r_ovf  = 1'($urandom_range(0, 1));
      r_en   = 1'($urandom_range(0, 1));
      in_diff = r_diff; in_ovf = r_ovf; sat_en = r_en;
      exp_w = ref_clamp(r_diff, r_ovf, r_en);
      if (r_ovf) exp_cnt++;
      step();
      check($sformatf("stream_%0d", i), {in_ready, out_valid, out_sat, out_data},
            {1'b1, 1'b1, exp_w});
    end
    check("stream_cnt", ovf_count, 64'(exp_cnt));
    in_valid = 0;
    step();
    check("stream_end_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_sat_stage_32bit_signed.md
SUB_SAT_STAGE_32BIT_SIGNED -- requirements
Module: sub_sat_stage_32bit_signed

Interface
REQ-001 Parameter CNT_W, default 16, width of the overflow event counter (legal range 4..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream difference word valid.
REQ-005 in_ready  output  1  stage can accept a word this cycle.
REQ-006 in_diff  input  32  signed wrapped difference from the subtractor stage.
REQ-007 in_ovf  input  1  overflow flag accompanying in_diff.
REQ-008 sat_en  input  1  1 = clamp overflowed words; 0 = pass wrapped value unchanged.
REQ-009 cnt_clr  input  1  synchronous clear of counter and sticky flag.
REQ-010 out_valid  output  1  output word valid.
REQ-011 out_ready  input  1  downstream accepts output word.
REQ-012 out_data  output  32  signed, possibly saturated difference.
REQ-013 out_sat  output  1  out_data was clamped.
REQ-014 ovf_sticky  output  1  set by any accepted overflowed word.
REQ-015 ovf_count  output  CNT_W  number of accepted overflowed words, saturating.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Stage SHALL be a 2-entry skid buffer: main register feeding outputs, one skid register; latency in-to-out exactly 1 cycle when the main register is empty or draining.
REQ-018 in_ready SHALL be a registered signal, low only while the skid register is occupied; no combinational path from out_ready to in_ready.
REQ-019 Buffer states SHALL be EMPTY (out_valid=0), ONE (main full), FULL (main+skid full); EMPTY->ONE on input; ONE->FULL on input without output; FULL->ONE on output (skid moves to main); ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output.
REQ-020 Saturation SHALL be decided at input acceptance: if sat_en && in_ovf, stored data = 32'h7FFF_FFFF when in_diff[31]=1, 32'h8000_0000 when in_diff[31]=0, and stored sat bit = 1; else data = in_diff, sat bit = 0.
REQ-021 out_data/out_sat SHALL hold stable while out_valid && !out_ready.
REQ-022 On each accepted word with in_ovf=1, ovf_count SHALL increment by 1, holding at 2^CNT_W-1 (no wrap), and ovf_sticky SHALL set, independent of sat_en.
REQ-023 cnt_clr SHALL zero ovf_count and ovf_sticky next cycle; if an overflowed word is accepted in the same cycle, clear wins and the result is count=1, sticky=1.
REQ-024 sat_en and cnt_clr SHALL not affect words already buffered.
REQ-025 No word SHALL be dropped or duplicated; order SHALL be preserved.

Reset
REQ-026 On rst assertion, without waiting for clk: out_valid=0, in_ready=1, out_data=0, out_sat=0, ovf_count=0, ovf_sticky=0, buffer state EMPTY.
REQ-027 Reset mid-transfer SHALL discard both buffered words; first post-reset input SHALL appear after 1 cycle.

Structure
REQ-028 Package sub_stage_pkg SHALL hold DATA_W=32, SAT_MAX=32'h7FFF_FFFF, SAT_MIN=32'h8000_0000 and the buffer-state enum.
REQ-029 Saturation logic SHALL be a combinational sub-module sub_sat_clamp (in_diff, in_ovf, sat_en -> data, sat); registers and counter stay in the top.

Verification
REQ-030 sat_en=1, in_diff=32'h8000_0001, in_ovf=1, out_ready=1 -> next cycle out_data=32'h7FFF_FFFF, out_sat=1, ovf_count=1.
REQ-031 sat_en=0, in_diff=32'h7FFF_FFFE, in_ovf=1 -> out_data=32'h7FFF_FFFE, out_sat=0, ovf_sticky=1.
REQ-032 out_ready=0, three back-to-back valid words 5, 6, 7 -> words 5, 6 accepted, in_ready=0 on third; release out_ready -> outputs 5, 6, 7 in order, no gaps beyond 1 cycle.
REQ-033 CNT_W=4, 20 overflowed words -> ovf_count=15 holding; cnt_clr with overflowed word accepted same cycle -> count=1.
REQ-034 rst asserted with FULL buffer and out_ready=0 -> out_valid=0 and in_ready=1 immediately, no stale word emitted after release.
REQ-035 Continuous in_valid=out_ready=1 for 100 random words -> throughput 1 word/cycle, output equals reference clamp model.
